raspi_link_responder: RTL and testbench

- Responder end of the CD-ROM ↔ Raspberry Pi nibble link; sits where the Pi attaches and takes the drive role opposite the PSX-side CD-ROM controller.
- Decodes nibble-serialised command and parameter bytes, then presents a command record to local logic.
- For READN/READS, streams sector bytes from a local byte source back over the 8-bit data handshake until the initiator cancels.
- Used as an on-FPGA drive emulator and as the loopback partner for CD-ROM bring-up.

---
 rtl/raspi_link_responder.sv | 193 +++++++++++++++++++
 tb/tb_raspi_link_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/raspi_link_responder.sv
// Responder side of the CD-ROM <-> Raspberry Pi nibble link: decodes nibble-serialised
// command records and streams sector bytes back over the 8-bit ack/data handshake.
module raspi_link_responder #(
  parameter int         SYNC_STAGES  = 2,
  parameter int         SECTOR_BYTES = 2048,
  parameter logic [3:0] CANCEL_CODE  = 4'hA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  raspi_cmd,
  input  logic        raspi_en,
  output logic        raspi_ack,
  output logic [7:0]  raspi_data,
  output logic        cmd_strobe,
  output logic [7:0]  cmd_code,
  output logic [23:0] cmd_params,
  output logic [1:0]  param_cnt,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic        streaming,
  output logic        sector_done,
  output logic        cancel_strobe
);

  localparam int BW = $clog2(SECTOR_BYTES);

  typedef enum logic [2:0] {
    C_WAIT,
    C_ACK,
    DISPATCH,
    S_FETCH,
    S_PRESENT,
    S_RELEASE
  } state_t;

  state_t                       state;
  logic [SYNC_STAGES-1:0]       en_sync;
  logic [SYNC_STAGES-1:0][3:0]  cmd_sync;
  logic                         en_s;
  logic [3:0]                   cmd_s;
  logic [31:0]                  rx_buf;
  logic [2:0]                   nib_idx;
  logic                         armed;
  logic                         cancel_prev;
  logic [BW-1:0]                byte_cnt;
  logic [1:0]                   rx_pc;
  logic [23:0]                  rx_params;
  logic                         rx_is_stream;

  function automatic logic [1:0] param_count(input logic [7:0] code);
    case (code)
      8'h02:                      param_count = 2'd3;
      8'h0D:                      param_count = 2'd2;
      8'h0E, 8'h12, 8'h14, 8'h19: param_count = 2'd1;
      default:                    param_count = 2'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_sync  <= '0;
      cmd_sync <= '0;
    end else begin
      en_sync  <= {en_sync[SYNC_STAGES-2:0], raspi_en};
      cmd_sync <= {cmd_sync[SYNC_STAGES-2:0], raspi_cmd};
    end
  end

  assign en_s  = en_sync[SYNC_STAGES-1];
  assign cmd_s = cmd_sync[SYNC_STAGES-1];

  assign rx_pc        = param_count(rx_buf[7:0]);
  assign rx_is_stream = (rx_buf[7:0] == 8'h06) || (rx_buf[7:0] == 8'h1B);

  // Parameter bytes beyond the command's count may hold stale nibbles from earlier records.
  always_comb begin
    rx_params = rx_buf[31:8];
    if (rx_pc < 2'd3) rx_params[23:16] = 8'h00;
    if (rx_pc < 2'd2) rx_params[15:8]  = 8'h00;
    if (rx_pc < 2'd1) rx_params[7:0]   = 8'h00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= C_WAIT;
      rx_buf        <= '0;
      nib_idx       <= '0;
      armed         <= 1'b0;
      cancel_prev   <= 1'b0;
      byte_cnt      <= '0;
      raspi_ack     <= 1'b0;
      raspi_data    <= '0;
      cmd_strobe    <= 1'b0;
      cmd_code      <= '0;
      cmd_params    <= '0;
      param_cnt     <= '0;
      src_ready     <= 1'b0;
      streaming     <= 1'b0;
      sector_done   <= 1'b0;
      cancel_strobe <= 1'b0;
    end else begin
      cmd_strobe    <= 1'b0;
      src_ready     <= 1'b0;
      sector_done   <= 1'b0;
      cancel_strobe <= 1'b0;
      if (!en_s) armed <= 1'b1;

      case (state)
        C_WAIT: begin
          if (armed && en_s) begin
            rx_buf[{nib_idx, 2'b00} +: 4] <= cmd_s;
            raspi_ack <= 1'b1;
            state     <= C_ACK;
          end
        end

        // The last nibble index is odd, so the stale count seen at nibble 0 cannot end the record.
        C_ACK: begin
          if (!en_s) begin
            raspi_ack <= 1'b0;
            if (nib_idx == {rx_pc, 1'b1}) begin
              nib_idx <= '0;
              state   <= DISPATCH;
            end else begin
              nib_idx <= nib_idx + 3'd1;
              state   <= C_WAIT;
            end
          end
        end

        DISPATCH: begin
          cmd_code   <= rx_buf[7:0];
          cmd_params <= rx_params;
          param_cnt  <= rx_pc;
          cmd_strobe <= 1'b1;
          if (rx_is_stream) begin
            byte_cnt  <= '0;
            streaming <= 1'b1;
            state     <= S_FETCH;
          end else begin
            state <= C_WAIT;
          end
        end

        S_FETCH: begin
          if (src_valid && !en_s) begin
            src_ready   <= 1'b1;
            raspi_data  <= src_data;
            raspi_ack   <= 1'b1;
            cancel_prev <= 1'b0;
            state       <= S_PRESENT;
          end
        end

        // A consuming en_s rise takes priority over a pending cancel.
        S_PRESENT: begin
          if (en_s) begin
            raspi_ack   <= 1'b0;
            cancel_prev <= 1'b0;
            state       <= S_RELEASE;
            if (byte_cnt == BW'(SECTOR_BYTES - 1)) begin
              sector_done <= 1'b1;
              byte_cnt    <= '0;
            end else begin
              byte_cnt <= byte_cnt + BW'(1);
            end
          end else if (cmd_s == CANCEL_CODE) begin
            if (cancel_prev) begin
              raspi_ack     <= 1'b0;
              cancel_strobe <= 1'b1;
              streaming     <= 1'b0;
              cancel_prev   <= 1'b0;
              nib_idx       <= '0;
              state         <= C_WAIT;
            end else begin
              cancel_prev <= 1'b1;
            end
          end else begin
            cancel_prev <= 1'b0;
          end
        end

        S_RELEASE: begin
          if (!en_s) state <= S_FETCH;
        end

        default: state <= C_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_raspi_link_responder.sv
// Self-checking bench for raspi_link_responder: plays the initiator side of the nibble link
// and a byte source, comparing against a command table and a byte-queue model.
module tb_raspi_link_responder;

  localparam int         SYNC_STAGES  = 2;
  localparam int         SECTOR_BYTES = 4;
  localparam logic [3:0] CANCEL_CODE  = 4'hA;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  raspi_cmd = 4'h0;
  logic        raspi_en = 1'b0;
  logic        raspi_ack;
  logic [7:0]  raspi_data;
  logic        cmd_strobe;
  logic [7:0]  cmd_code;
  logic [23:0] cmd_params;
  logic [1:0]  param_cnt;
  logic [7:0]  src_data = 8'h00;
  logic        src_valid = 1'b0;
  logic        src_ready;
  logic        streaming;
  logic        sector_done;
  logic        cancel_strobe;

  raspi_link_responder #(
    .SYNC_STAGES (SYNC_STAGES),
    .SECTOR_BYTES(SECTOR_BYTES),
    .CANCEL_CODE (CANCEL_CODE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .raspi_cmd    (raspi_cmd),
    .raspi_en     (raspi_en),
    .raspi_ack    (raspi_ack),
    .raspi_data   (raspi_data),
    .cmd_strobe   (cmd_strobe),
    .cmd_code     (cmd_code),
    .cmd_params   (cmd_params),
    .param_cnt    (param_cnt),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .streaming    (streaming),
    .sector_done  (sector_done),
    .cancel_strobe(cancel_strobe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int sector_cnt = 0;
  int pop_cnt = 0;
  int cancel_cnt = 0;
  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];

  logic [7:0] pc_codes [6] = '{8'h02, 8'h0D, 8'h0E, 8'h12, 8'h14, 8'h19};
  int         pc_vals  [6] = '{3, 2, 1, 1, 1, 1};
  logic [7:0] code_pool[9] = '{8'h01, 8'h02, 8'h0D, 8'h0E, 8'h12, 8'h14, 8'h19, 8'h0A, 8'h03};

  // Pulse counters and the byte source, sampled just after each edge has settled.
  always @(posedge clk) begin
    #1;
    if (cmd_strobe)    strobe_cnt++;
    if (sector_done)   sector_cnt++;
    if (cancel_strobe) cancel_cnt++;
    if (src_ready) begin
      pop_cnt++;
      if (src_q.size() > 0) void'(src_q.pop_front());
    end
    src_valid = (src_q.size() > 0);
    src_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {16'd0, raspi_ack, raspi_data, cmd_strobe, cmd_code, cmd_params, param_cnt,
            src_ready, streaming, sector_done, cancel_strobe};
  endfunction

  function automatic int model_param_count(input logic [7:0] code);
    for (int i = 0; i < 6; i++) if (pc_codes[i] == code) return pc_vals[i];
    return 0;
  endfunction

  task automatic wait_ack(input logic level, input string tag, output int cycles);
    cycles = 0;
    while (raspi_ack !== level && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    check_output(tag, 64'(raspi_ack), 64'(level));
  endtask

  task automatic send_nibble(input logic [3:0] n);
    int cyc;
    raspi_cmd = n;
    raspi_en  = 1'b1;
    wait_ack(1'b1, "nibble_ack_rise", cyc);
    check_output("nibble_ack_latency", 64'(cyc), 64'(SYNC_STAGES + 1));
    raspi_en = 1'b0;
    wait_ack(1'b0, "nibble_ack_fall", cyc);
  endtask

  // Sends one full command record and checks the decoded result against the command table.
  task automatic apply_stimulus(input logic [7:0] code, input logic [7:0] p0,
                                input logic [7:0] p1, input logic [7:0] p2);
    logic [7:0]  bytes[4];
    logic [7:0]  b;
    logic [23:0] exp_params;
    int          n;
    int          base;
    n     = model_param_count(code);
    base  = strobe_cnt;
    bytes = '{code, p0, p1, p2};
    for (int k = 0; k < 2 * (n + 1); k++) begin
      if (k == 2 * (n + 1) - 1) check_output("no_early_strobe", 64'(strobe_cnt - base), 64'd0);
      b = bytes[k / 2];
      send_nibble((k % 2 == 0) ? b[3:0] : b[7:4]);
    end
    repeat (3) @(negedge clk);
    exp_params = 24'h0;
    for (int i = 0; i < n; i++) exp_params = exp_params | (24'(bytes[i + 1]) << (8 * i));
    check_output("strobe_once", 64'(strobe_cnt - base), 64'd1);
    check_output("cmd_code", 64'(cmd_code), 64'(code));
    check_output("cmd_params", 64'(cmd_params), 64'(exp_params));
    check_output("param_cnt", 64'(param_cnt), 64'(n));
    check_output("streaming_after_cmd", 64'(streaming),
                 64'((code == 8'h06) || (code == 8'h1B)));
  endtask

  task automatic stream_one(input int hold);
    int         cyc;
    int         pop_base;
    logic [7:0] exp_b;
    wait_ack(1'b1, "stream_ack_rise", cyc);
    exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check_output("stream_data", 64'(raspi_data), 64'(exp_b));
    check_output("stream_streaming", 64'(streaming), 64'd1);
    raspi_en = 1'b1;
    wait_ack(1'b0, "stream_ack_fall", cyc);
    if (hold > 0) begin
      pop_base = pop_cnt;
      repeat (hold) @(negedge clk);
      check_output("hold_no_pop", 64'(pop_cnt - pop_base), 64'd0);
      check_output("hold_ack_low", 64'(raspi_ack), 64'd0);
    end
    raspi_en = 1'b0;
  endtask

  task automatic cancel_stream();
    int         cyc;
    int         base;
    logic [7:0] exp_b;
    base = cancel_cnt;
    wait_ack(1'b1, "cancel_byte_ack", cyc);
    exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check_output("cancel_byte_data", 64'(raspi_data), 64'(exp_b));
    raspi_cmd = CANCEL_CODE;
    wait_ack(1'b0, "cancel_ack_fall", cyc);
    repeat (2) @(negedge clk);
    check_output("cancel_once", 64'(cancel_cnt - base), 64'd1);
    check_output("cancel_streaming", 64'(streaming), 64'd0);
    raspi_cmd = 4'h0;
    src_q.delete();
    exp_q.delete();
  endtask

  task automatic push_byte(input logic [7:0] b);
    src_q.push_back(b);
    exp_q.push_back(b);
  endtask

  initial begin
    int         pop_base;
    int         sec_base;
    logic [7:0] code;
    logic [7:0] directed[4];

    $display("[TB] start");
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_outputs", all_outputs(), 64'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    apply_stimulus(8'h01, 8'h00, 8'h00, 8'h00);
    apply_stimulus(8'h02, 8'h00, 8'h02, 8'h16);

    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 1) == 1) code = code_pool[$urandom_range(0, 8)];
      else code = 8'($urandom_range(0, 255));
      if (code == 8'h06 || code == 8'h1B) code = 8'h01;
      apply_stimulus(code, 8'($urandom), 8'($urandom), 8'($urandom));
    end

    // READN with an empty source, then a stray en pulse while fetching.
    apply_stimulus(8'h06, 8'h00, 8'h00, 8'h00);
    pop_base = pop_cnt;
    sec_base = sector_cnt;
    repeat (10) @(negedge clk);
    check_output("empty_src_ack", 64'(raspi_ack), 64'd0);
    check_output("empty_src_pop", 64'(pop_cnt - pop_base), 64'd0);
    raspi_en = 1'b1;
    repeat (6) @(negedge clk);
    check_output("stray_en_ack", 64'(raspi_ack), 64'd0);
    raspi_en = 1'b0;
    repeat (4) @(negedge clk);
    directed = '{8'hA5, 8'h5A, 8'h3C, 8'hC3};
    for (int i = 0; i < 4; i++) push_byte(directed[i]);
    for (int k = 1; k <= 4; k++) begin
      stream_one(0);
      check_output("sector_count", 64'(sector_cnt - sec_base), 64'(k / SECTOR_BYTES));
    end
    check_output("readn_pops", 64'(pop_cnt - pop_base), 64'd4);
    push_byte(8'h77);
    cancel_stream();

    // READS with random bytes, cancelled after two, then a normal command.
    apply_stimulus(8'h1B, 8'h00, 8'h00, 8'h00);
    sec_base = sector_cnt;
    for (int i = 0; i < 6; i++) push_byte(8'($urandom));
    stream_one(0);
    stream_one(0);
    cancel_stream();
    check_output("reads_no_sector", 64'(sector_cnt - sec_base), 64'd0);
    apply_stimulus(8'h01, 8'h00, 8'h00, 8'h00);

    // Sector boundaries over nine bytes, with back-pressure on byte 2.
    apply_stimulus(8'h06, 8'h00, 8'h00, 8'h00);
    sec_base = sector_cnt;
    for (int i = 0; i < 10; i++) push_byte(8'($urandom));
    for (int k = 1; k <= 9; k++) begin
      stream_one((k == 2) ? 20 : 0);
      check_output("sector_count", 64'(sector_cnt - sec_base), 64'(k / SECTOR_BYTES));
    end
    cancel_stream();

    // Reset asserted during the first parameter byte of SETLOC.
    sec_base = strobe_cnt;
    send_nibble(4'h2);
    send_nibble(4'h0);
    send_nibble(4'h0);
    raspi_cmd = 4'h0;
    raspi_en  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("midreset_outputs", all_outputs(), 64'd0);
    @(negedge clk);
    raspi_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_output("midreset_no_strobe", 64'(strobe_cnt - sec_base), 64'd0);
    apply_stimulus(8'h01, 8'h00, 8'h00, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
